// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. Each stage resolves one SEG-bit slice of the sum and passes its carry,
// the resolved low bits and the not-yet-consumed operand slices to the next stage. Valid/ready handshake.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;

    // One pipeline slot: operands (b already conditionally inverted), partial sum and running carry.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    stage_t in_st;
    logic   stall;

    assign stall    = st_q[STAGES-1].vld && !out_ready;
    assign in_ready = !stall;

    // Subtraction folds into addition here, so mode and carry-in travel as b' and the seed carry.
    always_comb begin
        in_st     = '0;
        in_st.vld = in_valid;
        in_st.a   = a;
        in_st.b   = sub ? ~b : b;
        in_st.c   = sub | cin;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         prv;
        stage_t         nxt;
        logic [SEG:0]   seg_sum;

        if (k == 0) begin : g_first
            assign prv = in_st;
        end else begin : g_next
            assign prv = st_q[k-1];
        end

        assign seg_sum = {1'b0, prv.a[k*SEG +: SEG]} + {1'b0, prv.b[k*SEG +: SEG]}
                       + {{SEG{1'b0}}, prv.c};

        // The MSB carry-in is recovered from the sum bit; ovf is only meaningful in the last stage.
        always_comb begin
            nxt                  = prv;
            nxt.s[k*SEG +: SEG]  = seg_sum[SEG-1:0];
            nxt.c                = seg_sum[SEG];
            nxt.ovf              = seg_sum[SEG-1] ^ prv.a[WIDTH-1] ^ prv.b[WIDTH-1] ^ seg_sum[SEG];
        end

        assign st_d[k] = nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
        end
    end

    assign out_valid = st_q[STAGES-1].vld;
    assign sum       = st_q[STAGES-1].s;
    assign cout      = st_q[STAGES-1].c;
    assign ovf       = st_q[STAGES-1].ovf;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three depths (4, 1, 8) share stimulus; each has an arithmetic scoreboard.
module tb_pipelined_addsub;
    localparam int W  = 32;
    localparam int NI = 3;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic                 clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
    logic [W-1:0]         a = '0, b = '0;
    logic [NI-1:0]        ir, ov, co, of;
    logic [NI-1:0][W-1:0] sm;
    int                   n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    function automatic int st_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
    endfunction

    // Reference: plain (W+1)-bit arithmetic, result packed as {sum, cout, ovf}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         v;
        bb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + (msub ? (W+1)'(1) : (W+1)'(mcin));
        v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {full[W-1:0], full[W], v};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int ST = (i == 0) ? 4 : ((i == 1) ? 1 : 8);
        logic [W+1:0] q[$];
        logic [W+1:0] exp_r;
        int           n_out = 0;
        logic         prev_stall = 0;
        logic [W+2:0] prev_out = '0;

        pipelined_addsub #(.WIDTH(W), .STAGES(ST)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[i]),
            .a(a), .b(b), .cin(cin), .sub(sub),
            .out_valid(ov[i]), .out_ready(out_ready),
            .sum(sm[i]), .cout(co[i]), .ovf(of[i])
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                prev_stall <= 1'b0;
            end else begin
                if (prev_stall)
                    chk($sformatf("hold_s%0d", ST), {ov[i], sm[i], co[i], of[i]}, prev_out);
                if (ov[i] && out_ready) begin
                    n_out <= n_out + 1;
                    exp_r = 'x;
                    if (q.size() != 0) exp_r = q.pop_front();
                    chk($sformatf("result_s%0d", ST), {sm[i], co[i], of[i]}, exp_r);
                end
                if (in_valid && ir[i]) q.push_back(model(a, b, cin, sub));
                prev_stall <= ov[i] && !out_ready;
                prev_out   <= {ov[i], sm[i], co[i], of[i]};
            end
        end
    end

    // Single beat into empty pipelines; measures latency of every depth and checks the depth-4 result.
    task automatic run_vec(input vec_t v);
        int           lat[NI];
        logic [W+1:0] got;
        got = '0;
        for (int i = 0; i < NI; i++) lat[i] = 0;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) in_valid = 0;
            for (int i = 0; i < NI; i++)
                if (lat[i] == 0 && ov[i]) begin
                    lat[i] = c;
                    if (i == 0) got = {sm[0], co[0], of[0]};
                end
        end
        for (int i = 0; i < NI; i++) chk($sformatf("latency_s%0d", st_of(i)), lat[i], st_of(i));
        chk("vec_result", got, {v.sum, v.cout, v.ovf});
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    vec_t tbl[10];
    int   n0, n8, bi;
    logic acc;

    initial begin
        tbl[0] = '{32'h0000_FFFF, 32'h1,         1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h0,         32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b0};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1};
        tbl[7] = '{32'h10,        32'h3,         1'b1, 1'b1, 32'hD,         1'b1, 1'b0};
        tbl[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
        tbl[9] = '{32'h0,         32'h1,         1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

        // Reset held 3 cycles with a valid beat presented.
        rst_n = 0; in_valid = 1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("rst_out_valid", ov[i], 0);
                chk("rst_sum", {sm[i], co[i], of[i]}, 0);
            end
        end
        @(posedge clk); #1; rst_n = 1; in_valid = 0;
        @(negedge clk);
        chk("in_ready_after_rst", ir, 3'b111);
        @(posedge clk); #1;

        for (int t = 0; t < 10; t++) run_vec(tbl[t]);

        // Backpressure: 8 beats back to back, out_ready low in cycles 5..7.
        n0 = g_dut[0].n_out; bi = 0;
        for (int c = 0; c < 40 && bi < 8; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = 1;
            a = bi * 32'h0101_0101 + 32'hFFFF; b = 32'h0000_FF01 + bi;
            cin = bi[0]; sub = bi[1];
            @(negedge clk);
            if (c >= 5 && c <= 7) chk("stall_in_ready", ir[0], 0);
            acc = ir[0];
            @(posedge clk); #1;
            if (acc) bi++;
        end
        in_valid = 0; out_ready = 1;
        repeat (12) @(posedge clk);
        #1;
        chk("bp_beat_count", g_dut[0].n_out - n0, 8);

        // Randomised mixed traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = $urandom_range(0, 4) != 0;
            a = pick(); b = pick();
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        repeat (12) @(posedge clk);
        #1;
        chk("drain_s4", g_dut[0].q.size(), 0);
        chk("drain_s1", g_dut[1].q.size(), 0);
        chk("drain_s8", g_dut[2].q.size(), 0);

        // Reset with 3 beats in flight, a beat presented during reset; then post-reset latency.
        n0 = g_dut[0].n_out; n8 = g_dut[2].n_out;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; a = 32'h100 * (k + 1); b = 32'h7; cin = 0; sub = 0;
            @(posedge clk); #1;
        end
        rst_n = 0; in_valid = 1;
        @(posedge clk); #1;
        rst_n = 1; in_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_out_s4", g_dut[0].n_out - n0, 0);
        chk("midrst_no_out_s8", g_dut[2].n_out - n8, 0);
        run_vec(tbl[0]);
        run_vec(tbl[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
